spi_slave_sync: RTL and testbench

Parametrised SPI slave, fully synchronous to the system clock. It replaces the SCK-clocked 8-bit slave: word width, SPI mode and bit order are parameters, and SCK, CS and MOSI are oversampled through synchronisers. It adds a valid/ready TX holding register, a one-cycle RX word strobe and an underrun flag. It sits between the board SPI pins and the glue logic that consumes received words and supplies reply words.

---
 rtl/spi_slave_sync_pkg.sv | 27 ++
 rtl/spi_slave_sync_if.sv | 32 +++
 rtl/spi_slave_sync_sync_bit.sv | 32 +++
 rtl/spi_slave_sync.sv | 169 ++++++++++++++++
 tb/tb_spi_slave_sync.sv | 382 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/spi_slave_sync_pkg.sv
// spi_slave_sync_pkg
//   Shared definitions for the oversampled SPI slave: SPI mode encodings
//   ({CPOL, CPHA} pairs), legal parameter bounds and a helper that tells
//   which SCK edge is the sample edge for a given mode.
package spi_slave_sync_pkg;

   // Legal parameter ranges, checked at elaboration by the top level.
   localparam int WIDTH_MIN       = 4;
   localparam int WIDTH_MAX       = 32;
   localparam int SYNC_STAGES_MIN = 2;

   // Mode encoding is {CPOL, CPHA}.
   typedef enum logic [1:0] {
      SPI_MODE0 = 2'b00,
      SPI_MODE1 = 2'b01,
      SPI_MODE2 = 2'b10,
      SPI_MODE3 = 2'b11
   } spi_mode_e;

   // The leading edge is rising when CPOL=0. Sampling happens on the
   // leading edge for CPHA=0 and on the trailing edge for CPHA=1, so the
   // sample edge is rising exactly when CPOL equals CPHA.
   function automatic logic sample_on_rise(input spi_mode_e mode);
      return (mode[1] == mode[0]);
   endfunction

endpackage

// File: rtl/spi_slave_sync_if.sv
// spi_slave_sync_if
//   Glue-side bus of the SPI slave: the TX holding-register handshake and
//   the RX word / status strobes.
//   tx_data_i/tx_valid_i -> slave, tx_ready_o <- slave: a word moves into
//     the holding register in any cycle where tx_valid_i and tx_ready_o
//     are both high; tx_data_i is ignored while tx_ready_o is low.
//   rx_data_o     <- last complete received word
//   rx_valid_o    <- one-cycle strobe, rx_data_o just updated
//   tx_underrun_o <- one-cycle strobe, a word load found the holding
//                    register empty and sent zeros
interface spi_slave_sync_if #(
   parameter int WIDTH = 8
) ();
   import spi_slave_sync_pkg::*;

   logic [WIDTH-1:0] tx_data_i;
   logic             tx_valid_i;
   logic             tx_ready_o;
   logic [WIDTH-1:0] rx_data_o;
   logic             rx_valid_o;
   logic             tx_underrun_o;

   modport slave (
      input  tx_data_i, tx_valid_i,
      output tx_ready_o, rx_data_o, rx_valid_o, tx_underrun_o
   );

   modport master (
      output tx_data_i, tx_valid_i,
      input  tx_ready_o, rx_data_o, rx_valid_o, tx_underrun_o
   );
endinterface

// File: rtl/spi_slave_sync_sync_bit.sv
// sync_bit
//   Single-bit synchroniser chain of STAGES flip-flops with an
//   asynchronous active-low reset to RST_VAL.
//   clk_i   in : destination clock
//   rst_n_i in : asynchronous active-low reset
//   d_i     in : asynchronous input
//   q_o     out: synchronised output
module sync_bit
   import spi_slave_sync_pkg::*;
#(
   parameter int STAGES  = 2,
   parameter bit RST_VAL = 1'b0
) (
   input  logic clk_i,
   input  logic rst_n_i,
   input  logic d_i,
   output logic q_o
);

   logic [STAGES-1:0] sync_q;
   logic [STAGES-1:0] sync_d;

   assign sync_d = {sync_q[STAGES-2:0], d_i};

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) sync_q <= {STAGES{RST_VAL}};
      else          sync_q <= sync_d;
   end

   assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/spi_slave_sync.sv
// spi_slave_sync
//   SPI slave running entirely on the system clock. SCK, CS and MOSI are
//   oversampled through synchronisers; SCK edges are found by comparing
//   successive synchronised values.
//   clk_i, rst_n_i        : system clock, asynchronous active-low reset
//   spi_sck_i/cs_i/mosi_i : SPI pins from the master (CS active low)
//   spi_miso_o            : slave data out
//   spi_miso_oe_o         : MISO output enable, high while selected
//   glue_if               : TX holding handshake and RX/underrun strobes
module spi_slave_sync
   import spi_slave_sync_pkg::*;
#(
   parameter int WIDTH       = 8,
   parameter bit CPOL        = 1'b0,
   parameter bit CPHA        = 1'b0,
   parameter bit MSB_FIRST   = 1'b1,
   parameter int SYNC_STAGES = 2
) (
   input  logic               clk_i,
   input  logic               rst_n_i,
   input  logic               spi_sck_i,
   input  logic               spi_cs_i,
   input  logic               spi_mosi_i,
   output logic               spi_miso_o,
   output logic               spi_miso_oe_o,
   spi_slave_sync_if.slave    glue_if
);

   localparam int                CNT_W    = $clog2(WIDTH);
   localparam spi_mode_e         MODE     = spi_mode_e'({CPOL, CPHA});
   localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(WIDTH - 1);

   if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
      $error("spi_slave_sync: WIDTH out of range 4..32");
   end
   if (SYNC_STAGES < SYNC_STAGES_MIN) begin : g_bad_sync
      $error("spi_slave_sync: SYNC_STAGES must be at least 2");
   end

   logic sck_s, cs_s, mosi_s;

   // Idle values: SCK rests at CPOL, CS rests deselected.
   sync_bit #(.STAGES(SYNC_STAGES), .RST_VAL(CPOL)) u_sync_sck (
      .clk_i(clk_i), .rst_n_i(rst_n_i), .d_i(spi_sck_i), .q_o(sck_s));
   sync_bit #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
      .clk_i(clk_i), .rst_n_i(rst_n_i), .d_i(spi_cs_i), .q_o(cs_s));
   sync_bit #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
      .clk_i(clk_i), .rst_n_i(rst_n_i), .d_i(spi_mosi_i), .q_o(mosi_s));

   logic             sck_prev_q, sel_prev_q;
   logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
   logic [WIDTH-1:0] rx_sr_q, rx_sr_d;
   logic [WIDTH-1:0] tx_sr_q, tx_sr_d;
   logic [WIDTH-1:0] hold_q, hold_d;
   logic             hold_full_q, hold_full_d;
   logic [WIDTH-1:0] rx_data_q, rx_data_d;
   logic             rx_valid_q, rx_valid_d;
   logic             underrun_q, underrun_d;
   logic             load_pend_q, load_pend_d;

   logic sel, sel_rise, sck_rise, sck_fall;
   logic sample_edge, shift_edge, load, accept;
   logic [WIDTH-1:0] rx_next, tx_shifted;

   assign sel      = ~cs_s;
   assign sel_rise = sel & ~sel_prev_q;
   assign sck_rise = sck_s & ~sck_prev_q;
   assign sck_fall = ~sck_s & sck_prev_q;

   assign sample_edge = sel & (sample_on_rise(MODE) ? sck_rise : sck_fall);
   assign shift_edge  = sel & (sample_on_rise(MODE) ? sck_fall : sck_rise);

   // CPHA=0 must present bit 0 before the first sample edge, so it loads on
   // select and on the shift edge after a word's last sample. CPHA=1 shifts
   // out on the leading edge, so the first shift edge of a word loads.
   assign load = CPHA ? (shift_edge & (bit_cnt_q == '0))
                      : (sel_rise | (shift_edge & load_pend_q));

   assign accept = glue_if.tx_valid_i & ~hold_full_q;

   assign rx_next    = MSB_FIRST ? {rx_sr_q[WIDTH-2:0], mosi_s}
                                 : {mosi_s, rx_sr_q[WIDTH-1:1]};
   assign tx_shifted = MSB_FIRST ? {tx_sr_q[WIDTH-2:0], 1'b0}
                                 : {1'b0, tx_sr_q[WIDTH-1:1]};

   always_comb begin
      bit_cnt_d   = bit_cnt_q;
      rx_sr_d     = rx_sr_q;
      tx_sr_d     = tx_sr_q;
      hold_d      = hold_q;
      hold_full_d = hold_full_q;
      rx_data_d   = rx_data_q;
      rx_valid_d  = 1'b0;
      underrun_d  = 1'b0;
      load_pend_d = load_pend_q;

      if (!sel) begin
         // Deselect abandons the word in flight; the holding register stays.
         bit_cnt_d   = '0;
         rx_sr_d     = '0;
         tx_sr_d     = '0;
         load_pend_d = 1'b0;
      end else begin
         if (sample_edge) begin
            rx_sr_d = rx_next;
            if (bit_cnt_q == LAST_BIT) begin
               bit_cnt_d   = '0;
               rx_data_d   = rx_next;
               rx_valid_d  = 1'b1;
               load_pend_d = ~CPHA;
            end else begin
               bit_cnt_d = bit_cnt_q + 1'b1;
            end
         end
         if (load) begin
            tx_sr_d     = hold_full_q ? hold_q : '0;
            underrun_d  = ~hold_full_q;
            load_pend_d = 1'b0;
         end else if (shift_edge) begin
            tx_sr_d = tx_shifted;
         end
      end

      // accept needs an empty register and a consuming load needs a full one,
      // so at most one of these applies; an empty-register load never bypasses.
      if (accept) begin
         hold_d      = glue_if.tx_data_i;
         hold_full_d = 1'b1;
      end else if (load && hold_full_q) begin
         hold_full_d = 1'b0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         sck_prev_q  <= CPOL;
         sel_prev_q  <= 1'b0;
         bit_cnt_q   <= '0;
         rx_sr_q     <= '0;
         tx_sr_q     <= '0;
         hold_q      <= '0;
         hold_full_q <= 1'b0;
         rx_data_q   <= '0;
         rx_valid_q  <= 1'b0;
         underrun_q  <= 1'b0;
         load_pend_q <= 1'b0;
      end else begin
         sck_prev_q  <= sck_s;
         sel_prev_q  <= sel;
         bit_cnt_q   <= bit_cnt_d;
         rx_sr_q     <= rx_sr_d;
         tx_sr_q     <= tx_sr_d;
         hold_q      <= hold_d;
         hold_full_q <= hold_full_d;
         rx_data_q   <= rx_data_d;
         rx_valid_q  <= rx_valid_d;
         underrun_q  <= underrun_d;
         load_pend_q <= load_pend_d;
      end
   end

   assign spi_miso_o            = MSB_FIRST ? tx_sr_q[WIDTH-1] : tx_sr_q[0];
   assign spi_miso_oe_o         = sel;
   assign glue_if.tx_ready_o    = ~hold_full_q;
   assign glue_if.rx_data_o     = rx_data_q;
   assign glue_if.rx_valid_o    = rx_valid_q;
   assign glue_if.tx_underrun_o = underrun_q;

endmodule

// File: tb/tb_spi_slave_sync.sv
// tb_spi_slave_sync
//   Three slaves share SCK and MOSI, each with its own CS:
//     A: WIDTH=8,  mode 0, MSB first
//     B: WIDTH=16, mode 3, MSB first
//     C: WIDTH=8,  mode 1, LSB first
//   A bit-level SPI master drives them; expectations come from word-level
//   rules (what the holding register held, what was sent on MOSI).
module tb_spi_slave_sync;
   localparam int HALF = 8;  // clk cycles per SCK half period (16x ratio)

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic       rst_n;
   logic       sck, mosi;
   logic [2:0] cs;
   logic       miso_a, oe_a, miso_b, oe_b, miso_c, oe_c;

   spi_slave_sync_if #(.WIDTH(8))  a_if ();
   spi_slave_sync_if #(.WIDTH(16)) b_if ();
   spi_slave_sync_if #(.WIDTH(8))  c_if ();

   spi_slave_sync #(.WIDTH(8), .CPOL(1'b0), .CPHA(1'b0), .MSB_FIRST(1'b1), .SYNC_STAGES(2)) u_a (
      .clk_i(clk), .rst_n_i(rst_n), .spi_sck_i(sck), .spi_cs_i(cs[0]), .spi_mosi_i(mosi),
      .spi_miso_o(miso_a), .spi_miso_oe_o(oe_a), .glue_if(a_if));
   spi_slave_sync #(.WIDTH(16), .CPOL(1'b1), .CPHA(1'b1), .MSB_FIRST(1'b1), .SYNC_STAGES(2)) u_b (
      .clk_i(clk), .rst_n_i(rst_n), .spi_sck_i(sck), .spi_cs_i(cs[1]), .spi_mosi_i(mosi),
      .spi_miso_o(miso_b), .spi_miso_oe_o(oe_b), .glue_if(b_if));
   spi_slave_sync #(.WIDTH(8), .CPOL(1'b0), .CPHA(1'b1), .MSB_FIRST(1'b0), .SYNC_STAGES(2)) u_c (
      .clk_i(clk), .rst_n_i(rst_n), .spi_sck_i(sck), .spi_cs_i(cs[2]), .spi_mosi_i(mosi),
      .spi_miso_o(miso_c), .spi_miso_oe_o(oe_c), .glue_if(c_if));

   // ---------------- scoreboard state ----------------
   int          n_total = 0;
   int          n_pass  = 0;
   int          unr_cnt = 0;
   logic [31:0] rx_got_q[$];
   logic [31:0] exp_q[$];

   always @(negedge clk) begin
      if (a_if.rx_valid_o) rx_got_q.push_back(32'(a_if.rx_data_o));
      if (b_if.rx_valid_o) rx_got_q.push_back(32'(b_if.rx_data_o));
      if (c_if.rx_valid_o) rx_got_q.push_back(32'(c_if.rx_data_o));
      if (a_if.tx_underrun_o) unr_cnt++;
      if (b_if.tx_underrun_o) unr_cnt++;
      if (c_if.tx_underrun_o) unr_cnt++;
   end

   // ---------------- DUT access ----------------
   function automatic logic get_miso(input int idx);
      return (idx == 0) ? miso_a : (idx == 1) ? miso_b : miso_c;
   endfunction

   function automatic logic get_ready(input int idx);
      return (idx == 0) ? a_if.tx_ready_o : (idx == 1) ? b_if.tx_ready_o : c_if.tx_ready_o;
   endfunction

   function automatic logic [31:0] get_rx_data(input int idx);
      return (idx == 0) ? 32'(a_if.rx_data_o) : (idx == 1) ? 32'(b_if.rx_data_o) : 32'(c_if.rx_data_o);
   endfunction

   // {miso, oe, tx_ready, rx_valid, tx_underrun}
   function automatic logic [4:0] outs_vec(input int idx);
      case (idx)
         0:       return {miso_a, oe_a, a_if.tx_ready_o, a_if.rx_valid_o, a_if.tx_underrun_o};
         1:       return {miso_b, oe_b, b_if.tx_ready_o, b_if.rx_valid_o, b_if.tx_underrun_o};
         default: return {miso_c, oe_c, c_if.tx_ready_o, c_if.rx_valid_o, c_if.tx_underrun_o};
      endcase
   endfunction

   // ---------------- reference model helpers ----------------
   // Wire order of up to two words: bit i of the stream is the i-th bit on
   // the line, taken MSB-down or LSB-up from each word.
   function automatic logic [63:0] words_to_stream(input logic [31:0] w0, input logic [31:0] w1,
                                                   input int width, input bit msbf);
      logic [63:0] s;
      logic [31:0] w;
      s = '0;
      for (int k = 0; k < 2; k++) begin
         w = (k == 0) ? w0 : w1;
         for (int i = 0; i < width; i++) s[k*width+i] = msbf ? w[width-1-i] : w[i];
      end
      return s;
   endfunction

   function automatic logic [31:0] stream_word(input logic [63:0] s, input int k,
                                               input int width, input bit msbf);
      logic [31:0] w;
      w = '0;
      for (int i = 0; i < width; i++) begin
         if (msbf) w[width-1-i] = s[k*width+i];
         else      w[i]         = s[k*width+i];
      end
      return w;
   endfunction

   // ---------------- driver tasks ----------------
   task automatic half_period();
      repeat (HALF) @(negedge clk);
   endtask

   task automatic set_tx(input int idx, input logic v, input logic [31:0] d);
      case (idx)
         0:       begin a_if.tx_valid_i = v; a_if.tx_data_i = d[7:0];  end
         1:       begin b_if.tx_valid_i = v; b_if.tx_data_i = d[15:0]; end
         default: begin c_if.tx_valid_i = v; c_if.tx_data_i = d[7:0];  end
      endcase
   endtask

   // Offer a word until the holding register takes it (bounded wait).
   task automatic push_tx(input int idx, input logic [31:0] d);
      int   waited;
      logic rdy;
      waited = 0;
      @(negedge clk);
      set_tx(idx, 1'b1, d);
      rdy = get_ready(idx);
      while (!rdy && waited < 400) begin
         @(negedge clk);
         waited++;
         rdy = get_ready(idx);
      end
      n_total++;
      if (rdy !== 1'b1) $display("FAIL push_tx_timeout[%0d]: tx_ready %b, required 1", idx, rdy);
      else              n_pass++;
      @(negedge clk);
      set_tx(idx, 1'b0, 32'h0);
   endtask

   // Bit-level SPI master: nbits on the wire with CS held low throughout.
   task automatic spi_xfer(input int idx, input bit cpol, input bit cpha, input int nbits,
                           input logic [63:0] mosi_bits, output logic [63:0] miso_bits);
      miso_bits = '0;
      sck  = cpol;
      mosi = 1'b0;
      half_period();
      cs[idx] = 1'b0;
      if (!cpha) mosi = mosi_bits[0];
      half_period();
      for (int i = 0; i < nbits; i++) begin
         if (!cpha) begin
            miso_bits[i] = get_miso(idx);
            sck = ~cpol;
            half_period();
            sck = cpol;
            if (i + 1 < nbits) mosi = mosi_bits[i+1];
            half_period();
         end else begin
            sck  = ~cpol;
            mosi = mosi_bits[i];
            half_period();
            miso_bits[i] = get_miso(idx);
            sck = cpol;
            half_period();
         end
      end
      cs[idx] = 1'b1;
      half_period();
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst_n = 1'b0;
      cs    = 3'b111;
      sck   = 1'b0;
      mosi  = 1'b0;
      set_tx(0, 1'b0, 32'h0);
      set_tx(1, 1'b0, 32'h0);
      set_tx(2, 1'b0, 32'h0);
      repeat (3) @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         n_total++;
         if (outs_vec(i) !== 5'b00100)
            $display("FAIL reset_outs[%0d]: {miso,oe,rdy,rxv,unr}=%b, required 00100", i, outs_vec(i));
         else n_pass++;
         n_total++;
         if (get_rx_data(i) !== 32'h0)
            $display("FAIL reset_rx_data[%0d]: %0h, required 0", i, get_rx_data(i));
         else n_pass++;
      end
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
   endtask

   task automatic test_mode0_basic();
      logic [63:0] s_out;
      logic [31:0] got;
      rx_got_q.delete();
      unr_cnt = 0;
      push_tx(0, 32'hA5);
      spi_xfer(0, 1'b0, 1'b0, 8, words_to_stream(32'h3C, 32'h0, 8, 1'b1), s_out);
      got = stream_word(s_out, 0, 8, 1'b1);
      n_total++;
      if (got !== 32'hA5) $display("FAIL mode0_master_rx: %0h, required a5", got); else n_pass++;
      n_total++;
      if (get_rx_data(0) !== 32'h3C) $display("FAIL mode0_rx_data: %0h, required 3c", get_rx_data(0)); else n_pass++;
      n_total++;
      if (rx_got_q.size() != 1) $display("FAIL mode0_rx_pulses: %0d, required 1", rx_got_q.size()); else n_pass++;
      // The reload after the last bit finds the holding register empty.
      n_total++;
      if (unr_cnt != 1) $display("FAIL mode0_underruns: %0d, required 1", unr_cnt); else n_pass++;
      n_total++;
      if (get_ready(0) !== 1'b1) $display("FAIL mode0_ready: %b, required 1", get_ready(0)); else n_pass++;
   endtask

   task automatic test_back_to_back();
      logic [63:0] s_out;
      logic [31:0] w0, w1, got;
      rx_got_q.delete();
      unr_cnt = 0;
      w0 = 32'($urandom_range(0, 16'hFFFF));
      w1 = 32'($urandom_range(0, 16'hFFFF));
      exp_q = '{w0, w1};
      push_tx(1, 32'h1234);
      fork
         spi_xfer(1, 1'b1, 1'b1, 32, words_to_stream(w0, w1, 16, 1'b1), s_out);
         begin
            repeat (60) @(negedge clk);
            push_tx(1, 32'hBEEF);
         end
      join
      got = stream_word(s_out, 0, 16, 1'b1);
      n_total++;
      if (got !== 32'h1234) $display("FAIL b2b_master_rx0: %0h, required 1234", got); else n_pass++;
      got = stream_word(s_out, 1, 16, 1'b1);
      n_total++;
      if (got !== 32'hBEEF) $display("FAIL b2b_master_rx1: %0h, required beef", got); else n_pass++;
      n_total++;
      if (rx_got_q.size() != 2) $display("FAIL b2b_rx_pulses: %0d, required 2", rx_got_q.size()); else n_pass++;
      for (int k = 0; k < 2; k++) begin
         got = (rx_got_q.size() > k) ? rx_got_q[k] : 32'hFFFF_FFFF;
         n_total++;
         if (got !== exp_q[k]) $display("FAIL b2b_rx_word%0d: %0h, required %0h", k, got, exp_q[k]); else n_pass++;
      end
      n_total++;
      if (unr_cnt != 0) $display("FAIL b2b_underruns: %0d, required 0", unr_cnt); else n_pass++;
   endtask

   task automatic test_lsb_first();
      logic [63:0] s_out;
      logic [31:0] got;
      rx_got_q.delete();
      unr_cnt = 0;
      push_tx(2, 32'h80);
      spi_xfer(2, 1'b0, 1'b1, 8, words_to_stream(32'h01, 32'h0, 8, 1'b0), s_out);
      got = stream_word(s_out, 0, 8, 1'b0);
      n_total++;
      if (got !== 32'h80) $display("FAIL lsb_master_rx: %0h, required 80", got); else n_pass++;
      n_total++;
      if (s_out[7:0] !== 8'h80) $display("FAIL lsb_wire_order: %0h, required 80", s_out[7:0]); else n_pass++;
      n_total++;
      if (get_rx_data(2) !== 32'h01) $display("FAIL lsb_rx_data: %0h, required 1", get_rx_data(2)); else n_pass++;
      n_total++;
      if (unr_cnt != 0) $display("FAIL lsb_underruns: %0d, required 0", unr_cnt); else n_pass++;
   endtask

   task automatic test_underrun();
      logic [63:0] s_out;
      logic [31:0] word, got;
      rx_got_q.delete();
      unr_cnt = 0;
      word = 32'($urandom_range(0, 255));
      fork
         spi_xfer(0, 1'b0, 1'b0, 8, words_to_stream(word, 32'h0, 8, 1'b1), s_out);
         begin
            // Arrives mid-word, so only the select-time load is empty.
            repeat (40) @(negedge clk);
            push_tx(0, 32'($urandom_range(0, 255)));
         end
      join
      got = stream_word(s_out, 0, 8, 1'b1);
      n_total++;
      if (got !== 32'h0) $display("FAIL underrun_master_rx: %0h, required 0", got); else n_pass++;
      n_total++;
      if (unr_cnt != 1) $display("FAIL underrun_pulses: %0d, required 1", unr_cnt); else n_pass++;
      n_total++;
      if (get_rx_data(0) !== word) $display("FAIL underrun_rx_data: %0h, required %0h", get_rx_data(0), word); else n_pass++;
   endtask

   task automatic test_abort();
      logic [63:0] s_out;
      logic [31:0] hold, got;
      rx_got_q.delete();
      unr_cnt = 0;
      spi_xfer(0, 1'b0, 1'b0, 5, 64'($urandom), s_out);
      n_total++;
      if (rx_got_q.size() != 0) $display("FAIL abort_partial_rx: %0d pulses, required 0", rx_got_q.size()); else n_pass++;
      hold = 32'($urandom_range(1, 255));
      push_tx(0, hold);
      spi_xfer(0, 1'b0, 1'b0, 8, words_to_stream(32'h55, 32'h0, 8, 1'b1), s_out);
      got = stream_word(s_out, 0, 8, 1'b1);
      n_total++;
      if (got !== hold) $display("FAIL abort_master_rx: %0h, required %0h", got, hold); else n_pass++;
      n_total++;
      if (rx_got_q.size() != 1) $display("FAIL abort_rx_pulses: %0d, required 1", rx_got_q.size()); else n_pass++;
      n_total++;
      if (get_rx_data(0) !== 32'h55) $display("FAIL abort_rx_data: %0h, required 55", get_rx_data(0)); else n_pass++;
      // Empty at the partial word's select, and at the full word's reload.
      n_total++;
      if (unr_cnt != 2) $display("FAIL abort_underruns: %0d, required 2", unr_cnt); else n_pass++;
   endtask

   task automatic test_random();
      logic [63:0] s_out;
      logic [31:0] hold, word, got;
      int          idx;
      bit          msbf, cpha;
      for (int n = 0; n < 6; n++) begin
         idx  = (n % 2 == 0) ? 0 : 2;
         msbf = (idx == 0);
         cpha = (idx == 2);
         hold = 32'($urandom_range(0, 255));
         word = 32'($urandom_range(0, 255));
         rx_got_q.delete();
         unr_cnt = 0;
         push_tx(idx, hold);
         spi_xfer(idx, 1'b0, cpha, 8, words_to_stream(word, 32'h0, 8, msbf), s_out);
         got = stream_word(s_out, 0, 8, msbf);
         n_total++;
         if (got !== hold) $display("FAIL rand_master_rx[%0d]: %0h, required %0h", n, got, hold); else n_pass++;
         n_total++;
         if (get_rx_data(idx) !== word) $display("FAIL rand_rx_data[%0d]: %0h, required %0h", n, get_rx_data(idx), word); else n_pass++;
         n_total++;
         if (rx_got_q.size() != 1) $display("FAIL rand_rx_pulses[%0d]: %0d, required 1", n, rx_got_q.size()); else n_pass++;
         // One word queued: a CPHA=0 slave also reloads after the last bit.
         n_total++;
         if (unr_cnt != (cpha ? 0 : 1)) $display("FAIL rand_underruns[%0d]: %0d, required %0d", n, unr_cnt, cpha ? 0 : 1); else n_pass++;
      end
   endtask

   task automatic test_reset_mid_word();
      logic [63:0] s_out;
      logic [31:0] hold, word, got;
      rx_got_q.delete();
      push_tx(0, 32'($urandom_range(1, 255)));
      fork
         spi_xfer(0, 1'b0, 1'b0, 8, 64'($urandom), s_out);
         begin
            repeat (60) @(negedge clk);
            rst_n = 1'b0;
            #1;
            n_total++;
            if (outs_vec(0) !== 5'b00100)
               $display("FAIL midrst_outs: {miso,oe,rdy,rxv,unr}=%b, required 00100", outs_vec(0));
            else n_pass++;
            n_total++;
            if (get_rx_data(0) !== 32'h0) $display("FAIL midrst_rx_data: %0h, required 0", get_rx_data(0)); else n_pass++;
         end
      join
      @(negedge clk);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      n_total++;
      if (rx_got_q.size() != 0) $display("FAIL midrst_rx_pulses: %0d, required 0", rx_got_q.size()); else n_pass++;
      hold = 32'($urandom_range(0, 255));
      word = 32'($urandom_range(0, 255));
      push_tx(0, hold);
      spi_xfer(0, 1'b0, 1'b0, 8, words_to_stream(word, 32'h0, 8, 1'b1), s_out);
      got = stream_word(s_out, 0, 8, 1'b1);
      n_total++;
      if (got !== hold) $display("FAIL midrst_after_master_rx: %0h, required %0h", got, hold); else n_pass++;
      n_total++;
      if (get_rx_data(0) !== word) $display("FAIL midrst_after_rx_data: %0h, required %0h", get_rx_data(0), word); else n_pass++;
      n_total++;
      if (get_ready(0) !== 1'b1) $display("FAIL midrst_after_ready: %b, required 1", get_ready(0)); else n_pass++;
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      test_reset();
      test_mode0_basic();
      test_back_to_back();
      test_lsb_first();
      test_underrun();
      test_abort();
      test_random();
      test_reset_mid_word();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
